// File: rtl/axis_pkt_fifo.sv
// AXI4-Stream FIFO carrying tdata/tkeep/tlast, with occupancy and packet counters.
// PKT_MODE=1 holds beats back until a complete packet (or a full FIFO) is stored.
module axis_pkt_fifo #(
    parameter int DATA_W   = 128,
    parameter int DEPTH    = 16,
    parameter int PKT_MODE = 0
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [DATA_W-1:0]      s_tdata,
    input  logic [DATA_W/8-1:0]    s_tkeep,
    input  logic                   s_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic [DATA_W/8-1:0]    m_tkeep,
    output logic                   m_tlast,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [$clog2(DEPTH):0] pkt_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int KEEP_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    beat_t            mem_q [DEPTH];
    beat_t            head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic             s_ready_q;
    logic             m_valid;
    logic             push;
    logic             pop;

    assign head = mem_q[rd_ptr_q];
    assign push = s_tvalid && s_ready_q;
    assign pop  = m_valid && m_tready;

    // In packet mode a full FIFO releases anyway, so a packet longer than DEPTH cannot deadlock.
    always_comb begin
        m_valid = (fill_q != '0);
        if (PKT_MODE != 0) begin
            m_valid = m_valid && ((pkt_q != '0) || (fill_q == FULL_LVL));
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        pkt_d    = pkt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   fill_d = fill_q + CNT_W'(1);
            2'b01:   fill_d = fill_q - CNT_W'(1);
            default: fill_d = fill_q;
        endcase
        case ({push && s_tlast, pop && head.last})
            2'b10:   pkt_d = pkt_q + CNT_W'(1);
            2'b01:   pkt_d = pkt_q - CNT_W'(1);
            default: pkt_d = pkt_q;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            pkt_q     <= '0;
            s_ready_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            pkt_q     <= pkt_d;
            s_ready_q <= (fill_d < FULL_LVL);
        end
    end

    // NOTE: storage is deliberately not reset; fill_q alone decides which entries are meaningful.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{data: s_tdata, keep: s_tkeep, last: s_tlast};
        end
    end

    // The head entry cannot be overwritten while presented: writes only land on it when empty.
    assign s_tready   = s_ready_q;
    assign m_tvalid   = m_valid;
    assign m_tdata    = m_valid ? head.data : '0;
    assign m_tkeep    = m_valid ? head.keep : '0;
    assign m_tlast    = m_valid && head.last;
    assign fill_level = fill_q;
    assign pkt_count  = pkt_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench for axis_pkt_fifo: three instances cover cut-through (16 deep),
// store-and-forward (16 deep) and store-and-forward with oversize packets (8 deep).
`timescale 1ns/1ps
module tb_axis_pkt_fifo;

    localparam int N  = 3;
    localparam int DW = 128;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_tvalid [N];
    logic [DW-1:0] s_tdata  [N];
    logic [KW-1:0] s_tkeep  [N];
    logic          s_tlast  [N];
    logic          m_tready [N];
    logic          s_tready [N];
    logic          m_tvalid [N];
    logic [DW-1:0] m_tdata  [N];
    logic [KW-1:0] m_tkeep  [N];
    logic          m_tlast  [N];
    logic [4:0]    fill_a   [2];
    logic [4:0]    pkt_a    [2];
    logic [3:0]    fill2, pkt2;

    beat_t sb [$];
    int    checks = 0;
    int    errors = 0;
    int    exp_fill [N];
    int    exp_pkt  [N];
    logic  stall_prev [N];
    beat_t stall_beat [N];
    int    coincident = 0;

    always #5 clk = ~clk;

    axis_pkt_fifo #(.DATA_W(DW), .DEPTH(16), .PKT_MODE(0)) u_dut0 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]), .s_tdata(s_tdata[0]),
        .s_tkeep(s_tkeep[0]), .s_tlast(s_tlast[0]),
        .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .m_tdata(m_tdata[0]),
        .m_tkeep(m_tkeep[0]), .m_tlast(m_tlast[0]),
        .fill_level(fill_a[0]), .pkt_count(pkt_a[0])
    );

    axis_pkt_fifo #(.DATA_W(DW), .DEPTH(16), .PKT_MODE(1)) u_dut1 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]), .s_tdata(s_tdata[1]),
        .s_tkeep(s_tkeep[1]), .s_tlast(s_tlast[1]),
        .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .m_tdata(m_tdata[1]),
        .m_tkeep(m_tkeep[1]), .m_tlast(m_tlast[1]),
        .fill_level(fill_a[1]), .pkt_count(pkt_a[1])
    );

    axis_pkt_fifo #(.DATA_W(DW), .DEPTH(8), .PKT_MODE(1)) u_dut2 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_tvalid(s_tvalid[2]), .s_tready(s_tready[2]), .s_tdata(s_tdata[2]),
        .s_tkeep(s_tkeep[2]), .s_tlast(s_tlast[2]),
        .m_tvalid(m_tvalid[2]), .m_tready(m_tready[2]), .m_tdata(m_tdata[2]),
        .m_tkeep(m_tkeep[2]), .m_tlast(m_tlast[2]),
        .fill_level(fill2), .pkt_count(pkt2)
    );

    function automatic int depth_of(input int d);
        return (d == 2) ? 8 : 16;
    endfunction

    function automatic int mode_of(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic logic [4:0] fill_of(input int d);
        return (d == 2) ? {1'b0, fill2} : fill_a[d];
    endfunction

    function automatic logic [4:0] pkt_of(input int d);
        return (d == 2) ? {1'b0, pkt2} : pkt_a[d];
    endfunction

    function automatic beat_t mk(input int i, input logic last);
        beat_t b;
        b.data = DW'(i);
        b.keep = KW'(i * 13 + 1);
        b.last = last;
        return b;
    endfunction

    function automatic beat_t rnd_beat(input logic last);
        beat_t b;
        b.data = {$urandom, $urandom, $urandom, $urandom};
        b.keep = KW'($urandom);
        b.last = last;
        return b;
    endfunction

    task automatic clear_model();
        sb.delete();
        for (int d = 0; d < N; d++) begin
            exp_fill[d]   = 0;
            exp_pkt[d]    = 0;
            stall_prev[d] = 1'b0;
            stall_beat[d] = '0;
            s_tvalid[d]   = 1'b0;
            s_tdata[d]    = '0;
            s_tkeep[d]    = '0;
            s_tlast[d]    = 1'b0;
            m_tready[d]   = 1'b0;
        end
    endtask

    // One clock of one instance: drive after a falling edge, compare against the model,
    // account for the handshakes of the coming rising edge, return at the next falling edge.
    task automatic cycle(input int d, input logic vld, input beat_t b, input logic rdy,
                         output logic pushed, output logic popped);
        beat_t got;
        beat_t exp;
        logic  exp_rdy;
        logic  exp_vld;
        s_tvalid[d] = vld;
        s_tdata[d]  = b.data;
        s_tkeep[d]  = b.keep;
        s_tlast[d]  = b.last;
        m_tready[d] = rdy;
        #1;
        exp     = '0;
        exp_rdy = (exp_fill[d] < depth_of(d));
        exp_vld = (exp_fill[d] != 0) &&
                  (mode_of(d) == 0 || exp_pkt[d] != 0 || exp_fill[d] == depth_of(d));
        got     = {m_tdata[d], m_tkeep[d], m_tlast[d]};
        checks++;
        if (fill_of(d) !== 5'(exp_fill[d])) begin
            errors++;
            $display("FAIL fill_level dut%0d t=%0t: got %0d expected %0d", d, $time, fill_of(d), exp_fill[d]);
        end
        checks++;
        if (pkt_of(d) !== 5'(exp_pkt[d])) begin
            errors++;
            $display("FAIL pkt_count dut%0d t=%0t: got %0d expected %0d", d, $time, pkt_of(d), exp_pkt[d]);
        end
        checks++;
        if (s_tready[d] !== exp_rdy) begin
            errors++;
            $display("FAIL s_tready dut%0d t=%0t: got %b expected %b", d, $time, s_tready[d], exp_rdy);
        end
        checks++;
        if (m_tvalid[d] !== exp_vld) begin
            errors++;
            $display("FAIL m_tvalid dut%0d t=%0t: got %b expected %b", d, $time, m_tvalid[d], exp_vld);
        end
        if (stall_prev[d]) begin
            checks++;
            if (m_tvalid[d] !== 1'b1 || got !== stall_beat[d]) begin
                errors++;
                $display("FAIL stall_hold dut%0d t=%0t: got %h expected %h", d, $time, got, stall_beat[d]);
            end
        end
        pushed = vld && (s_tready[d] === 1'b1);
        popped = (m_tvalid[d] === 1'b1) && rdy;
        if (popped) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_empty dut%0d t=%0t: got %h expected no beat", d, $time, got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL beat dut%0d t=%0t: got %h expected %h", d, $time, got, exp);
                end
            end
        end
        if (pushed) sb.push_back(b);
        if (pushed && b.last && popped && exp.last) coincident++;
        exp_fill[d] = exp_fill[d] + (pushed ? 1 : 0) - (popped ? 1 : 0);
        exp_pkt[d]  = exp_pkt[d] + ((pushed && b.last) ? 1 : 0) - ((popped && exp.last) ? 1 : 0);
        stall_prev[d] = m_tvalid[d] && !rdy;
        stall_beat[d] = got;
        @(negedge clk);
    endtask

    task automatic drain(input int d);
        logic pu, po;
        for (int c = 0; c < 200 && (sb.size() != 0 || exp_fill[d] != 0); c++) begin
            cycle(d, 1'b0, '0, 1'b1, pu, po);
        end
        checks++;
        if (sb.size() != 0 || fill_of(d) !== 5'd0) begin
            errors++;
            $display("FAIL drain_timeout dut%0d: got %0d beats left expected 0", d, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < N; d++) begin
                checks++;
                if ({s_tready[d], m_tvalid[d], m_tlast[d], m_tdata[d], m_tkeep[d], fill_of(d), pkt_of(d)} !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs dut%0d: got rdy=%b vld=%b last=%b data=%h keep=%h fill=%0d pkt=%0d expected all 0",
                             d, s_tready[d], m_tvalid[d], m_tlast[d], m_tdata[d], m_tkeep[d], fill_of(d), pkt_of(d));
                end
            end
        end
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < N; d++) begin
            checks++;
            if (s_tready[d] !== 1'b0) begin
                errors++;
                $display("FAIL ready_before_edge dut%0d: got %b expected 0", d, s_tready[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            checks++;
            if (s_tready[d] !== 1'b1 || m_tvalid[d] !== 1'b0) begin
                errors++;
                $display("FAIL ready_after_release dut%0d: got rdy=%b vld=%b expected rdy=1 vld=0", d, s_tready[d], m_tvalid[d]);
            end
        end
    endtask

    task automatic test_mode0_order();
        logic pu, po;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (fill_of(0) > 5'd1) begin
                errors++;
                $display("FAIL order_fill_bound: got %0d expected <= 1", fill_of(0));
            end
            cycle(0, 1'b1, mk(i, (i % 8) == 7), 1'b1, pu, po);
            checks++;
            if (!pu) begin
                errors++;
                $display("FAIL order_accept beat %0d: got no accept expected accept", i);
            end
        end
        drain(0);
    endtask

    task automatic test_full();
        logic pu, po;
        int   idx = 0;
        for (int c = 0; c < 20; c++) begin
            cycle(0, idx < 20, mk(idx + 'h100, 1'b0), 1'b0, pu, po);
            if (pu) idx++;
        end
        checks++;
        if (idx != 16 || fill_of(0) !== 5'd16 || s_tready[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_state: got accepted=%0d fill=%0d rdy=%b expected 16 16 0", idx, fill_of(0), s_tready[0]);
        end
        for (int c = 0; c < 100 && (idx < 20 || sb.size() != 0); c++) begin
            cycle(0, idx < 20, mk(idx + 'h100, idx == 19), 1'b1, pu, po);
            if (pu) idx++;
        end
        checks++;
        if (idx != 20) begin
            errors++;
            $display("FAIL full_resume: got accepted=%0d expected 20", idx);
        end
        drain(0);
    endtask

    task automatic test_pkt_mode();
        logic pu, po;
        for (int s = 0; s < 7; s++) begin
            cycle(1, s != 4 && s != 5, mk(s < 4 ? s + 'h200 : 'h204, s == 6), 1'b1, pu, po);
        end
        checks++;
        if (pkt_of(1) !== 5'd1 || m_tvalid[1] !== 1'b1 || fill_of(1) !== 5'd5) begin
            errors++;
            $display("FAIL saf_release: got pkt=%0d vld=%b fill=%0d expected 1 1 5", pkt_of(1), m_tvalid[1], fill_of(1));
        end
        drain(1);
        checks++;
        if (pkt_of(1) !== 5'd0) begin
            errors++;
            $display("FAIL saf_pkt_after: got %0d expected 0", pkt_of(1));
        end
    endtask

    task automatic test_oversize();
        logic pu, po;
        logic seen = 1'b0;
        int   idx  = 0;
        for (int c = 0; c < 200 && (idx < 12 || sb.size() != 0); c++) begin
            cycle(2, idx < 12, mk(idx + 'h300, idx == 11), 1'b1, pu, po);
            if (pu) idx++;
            if (!seen && m_tvalid[2] === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (fill_of(2) !== 5'd8) begin
                    errors++;
                    $display("FAIL oversize_release: got fill=%0d expected 8", fill_of(2));
                end
            end
        end
        checks++;
        if (idx != 12 || !seen || sb.size() != 0) begin
            errors++;
            $display("FAIL oversize_done: got accepted=%0d seen=%b left=%0d expected 12 1 0", idx, seen, sb.size());
        end
    endtask

    task automatic test_random(input int d);
        logic pu, po;
        int   n = 0;
        int   coinc0 = coincident;
        for (int c = 0; c < 8000 && n < 1000; c++) begin
            cycle(d, 1'($urandom_range(0, 1)),
                  rnd_beat(n == 999 || $urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), pu, po);
            if (pu) n++;
        end
        checks++;
        if (n != 1000 || coincident == coinc0) begin
            errors++;
            $display("FAIL random_run dut%0d: got pushes=%0d coincident_last=%0d expected 1000 and >0", d, n, coincident - coinc0);
        end
        drain(d);
    endtask

    task automatic test_reset_mid();
        logic pu, po;
        for (int i = 0; i < 5; i++) cycle(0, 1'b1, mk(i + 'h400, i == 2), 1'b0, pu, po);
        rst_n = 1'b0;
        #1;
        checks++;
        if (fill_of(0) !== 5'd0 || pkt_of(0) !== 5'd0 || s_tready[0] !== 1'b0 || m_tvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got fill=%0d pkt=%0d rdy=%b vld=%b expected all 0",
                     fill_of(0), pkt_of(0), s_tready[0], m_tvalid[0]);
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_tready[0] !== 1'b1 || m_tvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_release: got rdy=%b vld=%b expected 1 0", s_tready[0], m_tvalid[0]);
        end
        cycle(0, 1'b1, mk('h500, 1'b1), 1'b1, pu, po);
        drain(0);
    endtask

    initial begin
        clear_model();
        test_reset();
        test_mode0_order();
        test_full();
        test_pkt_mode();
        test_oversize();
        test_random(0);
        test_random(1);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
